// File: rtl/snake_move_ctrl_if.sv
// Game-side bundle of the snake motion engine: game status, keys and apple in; segments and hit flags out.
interface snake_move_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int MAX_LEN = 16
);
    logic [2:0]             Game_status;
    logic                   Key_left;
    logic                   Key_right;
    logic                   Key_up;
    logic                   Key_down;
    logic                   Apple_eaten;
    logic [X_W-1:0]         Head_x;
    logic [Y_W-1:0]         Head_y;
    logic [MAX_LEN*X_W-1:0] Body_x_flat;
    logic [MAX_LEN*Y_W-1:0] Body_y_flat;
    logic [4:0]             Body_len;
    logic                   Move_tick;
    logic                   Hit_wall_sig;
    logic                   Hit_body_sig;

    modport master (
        output Game_status, Key_left, Key_right, Key_up, Key_down, Apple_eaten,
        input  Head_x, Head_y, Body_x_flat, Body_y_flat, Body_len, Move_tick,
               Hit_wall_sig, Hit_body_sig
    );

    modport slave (
        input  Game_status, Key_left, Key_right, Key_up, Key_down, Apple_eaten,
        output Head_x, Head_y, Body_x_flat, Body_y_flat, Body_len, Move_tick,
               Hit_wall_sig, Hit_body_sig
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake motion engine: segment storage, heading, move divider, wall/body collision detection.
module snake_move_ctrl #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 20,
    parameter int INIT_Y   = 15,
    parameter int MOVE_DIV = 6000000
) (
    input  logic       Clk_24mhz,
    input  logic       Rst,
    snake_move_if.slave bus
);
    typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);

    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [X_W-1:0]   seg_x_d [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_d [MAX_LEN];
    logic [4:0]       len_q, len_d;
    dir_t             dir_q, dir_d, pend_q, pend_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             grow_q, grow_d;
    logic             tick_q, tick_d;
    logic             hit_wall_q, hit_wall_d;
    logic             hit_body_q, hit_body_d;

    logic             is_start, is_play, growing, wall, body, key_ok;
    logic [X_W-1:0]   nx;
    logic [Y_W-1:0]   ny;
    dir_t             key_dir;

    function automatic logic [X_W-1:0] init_x(input int i);
        return (i < INIT_LEN) ? X_W'(INIT_X - i) : '0;
    endfunction

    function automatic logic [Y_W-1:0] init_y(input int i);
        return (i < INIT_LEN) ? Y_W'(INIT_Y) : '0;
    endfunction

    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        div_d      = div_q;
        grow_d     = grow_q;
        tick_d     = 1'b0;
        hit_wall_d = hit_wall_q;
        hit_body_d = hit_body_q;
        is_start   = (bus.Game_status == 3'b001);
        is_play    = (bus.Game_status == 3'b010);
        growing    = grow_q && (len_q < LEN_MAX);
        nx         = seg_x_q[0];
        ny         = seg_y_q[0];
        wall       = 1'b0;
        body       = 1'b0;
        key_ok     = 1'b0;
        key_dir    = pend_q;

        case (pend_q)
            DIR_RIGHT: begin wall = (seg_x_q[0] == X_W'(GRID_W - 1)); nx = seg_x_q[0] + 1'b1; end
            DIR_LEFT:  begin wall = (seg_x_q[0] == '0);                nx = seg_x_q[0] - 1'b1; end
            DIR_UP:    begin wall = (seg_y_q[0] == '0);                ny = seg_y_q[0] - 1'b1; end
            DIR_DOWN:  begin wall = (seg_y_q[0] == Y_W'(GRID_H - 1)); ny = seg_y_q[0] + 1'b1; end
            default: ;
        endcase

        // The tail cell counts as body only when it stays put because the snake grows this step.
        for (int i = 1; i < MAX_LEN; i++) begin
            if (seg_x_q[i] == nx && seg_y_q[i] == ny &&
                ((i < int'(len_q) - 1) || (growing && i == int'(len_q) - 1)))
                body = 1'b1;
        end

        // Reversal is judged against the committed heading, so a rejected key falls to the next one.
        if (bus.Key_up && dir_q != DIR_DOWN)          begin key_ok = 1'b1; key_dir = DIR_UP;    end
        else if (bus.Key_down && dir_q != DIR_UP)     begin key_ok = 1'b1; key_dir = DIR_DOWN;  end
        else if (bus.Key_left && dir_q != DIR_RIGHT)  begin key_ok = 1'b1; key_dir = DIR_LEFT;  end
        else if (bus.Key_right && dir_q != DIR_LEFT)  begin key_ok = 1'b1; key_dir = DIR_RIGHT; end

        if (is_start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
            len_d      = LEN_INIT;
            dir_d      = DIR_RIGHT;
            pend_d     = DIR_RIGHT;
            div_d      = '0;
            grow_d     = 1'b0;
            hit_wall_d = 1'b0;
            hit_body_d = 1'b0;
        end else if (is_play) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == DIV_LAST && !hit_wall_q && !hit_body_q) begin
                dir_d = pend_q;
                if (wall) begin
                    hit_wall_d = 1'b1;
                end else if (body) begin
                    hit_body_d = 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nx;
                    seg_y_d[0] = ny;
                    if (growing) len_d = len_q + 5'd1;
                    grow_d = 1'b0;
                    tick_d = 1'b1;
                end
            end
            if (key_ok) pend_d = key_dir;
            if (bus.Apple_eaten) grow_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_24mhz) begin
        if (Rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            len_q      <= LEN_INIT;
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            div_q      <= '0;
            grow_q     <= 1'b0;
            tick_q     <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            div_q      <= div_d;
            grow_q     <= grow_d;
            tick_q     <= tick_d;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
        assign bus.Body_x_flat[g*X_W +: X_W] = seg_x_q[g];
        assign bus.Body_y_flat[g*Y_W +: Y_W] = seg_y_q[g];
    end

    assign bus.Head_x       = seg_x_q[0];
    assign bus.Head_y       = seg_y_q[0];
    assign bus.Body_len     = len_q;
    assign bus.Move_tick    = tick_q;
    assign bus.Hit_wall_sig = hit_wall_q;
    assign bus.Hit_body_sig = hit_body_q;
endmodule
